// File: rtl/ldpc_pkg.sv
// Shared constants and types for the LDPC input loader and its neighbours.
package ldpc_pkg;

  localparam int LDPC_N = 9216;
  localparam int LANES  = 12;
  localparam int WORDS  = 768;
  localparam int IW     = 8;
  localparam int QW     = 6;
  localparam int AW     = 10;

  // Symmetric LLR limits: the most-negative code is never stored.
  localparam int SAT_MAX = (1 << (QW - 1)) - 1;
  localparam int SAT_MIN = -SAT_MAX;

  // One-hot loader state encoding.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    LOAD = 3'b010,
    DONE = 3'b100
  } state_t;

endpackage

// File: rtl/ldpc_din_if.sv
// Soft-bit input stream plus LQ/channel RAM write port of the loader.
interface ldpc_din_if
  import ldpc_pkg::*;
#(
  parameter int IW    = ldpc_pkg::IW,
  parameter int QW    = ldpc_pkg::QW,
  parameter int LANES = ldpc_pkg::LANES,
  parameter int AW    = ldpc_pkg::AW
);

  logic                  din_valid;
  logic                  din_sop;
  logic [IW-1:0]         din;
  logic                  ready;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [LANES*QW-1:0]   wr_data;

  // Upstream source: drives samples, observes ready and the RAM writes.
  modport master (
    output din_valid, din_sop, din,
    input  ready, wr_en, wr_addr, wr_data
  );

  // Loader side.
  modport slave (
    input  din_valid, din_sop, din,
    output ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ldpc_din_quant.sv
// Soft-bit requantizer: arithmetic right shift then symmetric saturation.
module ldpc_din_quant #(
  parameter int IW    = 8,
  parameter int QW    = 6,
  parameter int SHIFT = 2
) (
  input  logic signed [IW-1:0] din,
  output logic signed [QW-1:0] q
);

  localparam logic signed [IW-1:0] POS_LIM = IW'((1 << (QW - 1)) - 1);
  localparam logic signed [IW-1:0] NEG_LIM = -POS_LIM;

  logic signed [IW-1:0] shifted;

  // Shift and clamp to [-POS_LIM, +POS_LIM].
  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > POS_LIM) begin
      q = POS_LIM[QW-1:0];
    end else if (shifted < NEG_LIM) begin
      q = NEG_LIM[QW-1:0];
    end else begin
      q = shifted[QW-1:0];
    end
  end

endmodule

// File: rtl/ldpc_din.sv
// LDPC input loader: requantizes a framed soft-bit stream, packs LANES LLRs
// per word, writes one codeword into the LQ RAM and frames it with sync_out.
//
// state | meaning
// IDLE  | waiting for sop; ready follows !dec_busy
// LOAD  | collecting samples, one RAM write per LANES samples
// DONE  | last word written; sync_out drops at the end of this cycle
module ldpc_din
  import ldpc_pkg::*;
#(
  parameter int IW    = ldpc_pkg::IW,
  parameter int QW    = ldpc_pkg::QW,
  parameter int SHIFT = 2,
  parameter int LANES = ldpc_pkg::LANES,
  parameter int WORDS = ldpc_pkg::WORDS,
  parameter int AW    = ldpc_pkg::AW
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dec_busy,
  output logic        sync_out,
  output logic        frame_err,
  output logic        frame_drop,
  ldpc_din_if.slave   bus
);

  localparam int              LW        = $clog2(LANES);
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);
  localparam logic [AW-1:0]   LAST_WORD = AW'(WORDS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [LW-1:0]         lane_cnt;
  logic [AW-1:0]         word_cnt;
  logic [LANES*QW-1:0]   pack;
  logic [LANES*QW-1:0]   pack_nxt;
  logic [LW-1:0]         lane_sel;
  logic signed [QW-1:0]  q;

  logic ready_c;
  logic sop_v;
  logic take_sop;
  logic drop_sop;
  logic restart;
  logic store;
  logic last_lane;
  logic last_word;

  ldpc_din_quant #(
    .IW    (IW),
    .QW    (QW),
    .SHIFT (SHIFT)
  ) u_quant (
    .din (bus.din),
    .q   (q)
  );

  assign bus.ready = ready_c;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle sample qualification.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    take_sop  = 1'b0;
    drop_sop  = 1'b0;
    restart   = 1'b0;
    store     = 1'b0;
    last_lane = 1'b0;
    last_word = 1'b0;
    sop_v     = bus.din_valid & bus.din_sop;

    case (state)
      IDLE, DONE: begin
        ready_c   = !dec_busy;
        take_sop  = sop_v & ready_c;
        drop_sop  = sop_v & !ready_c;
        state_nxt = take_sop ? LOAD : IDLE;
      end
      LOAD: begin
        // A sop here always wins, even on the final sample of the frame.
        restart   = sop_v;
        store     = bus.din_valid & !bus.din_sop;
        last_lane = store && (lane_cnt == LAST_LANE);
        last_word = last_lane && (word_cnt == LAST_WORD);
        if (last_word) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Insert the current LLR into its lane; a sop always lands in lane 0.
  always_comb begin
    lane_sel = (take_sop | restart) ? '0 : lane_cnt;
    pack_nxt = pack;
    pack_nxt[lane_sel*QW +: QW] = q;
  end

  // Counters, packing register, RAM write port and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt    <= '0;
      word_cnt    <= '0;
      pack        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      frame_err   <= 1'b0;
      frame_drop  <= 1'b0;
      sync_out    <= 1'b0;
    end else begin
      bus.wr_en  <= last_lane;
      frame_err  <= restart;
      frame_drop <= drop_sop;

      if (take_sop | restart) begin
        pack     <= pack_nxt;
        lane_cnt <= LW'(1);
        word_cnt <= '0;
      end else if (store) begin
        pack <= pack_nxt;
        if (last_lane) begin
          lane_cnt    <= '0;
          word_cnt    <= word_cnt + AW'(1);
          bus.wr_addr <= word_cnt;
          bus.wr_data <= pack_nxt;
        end else begin
          lane_cnt <= lane_cnt + LW'(1);
        end
      end

      // sync_out stays high across a restart or a back-to-back frame.
      if (take_sop) begin
        sync_out <= 1'b1;
      end else if (state == DONE) begin
        sync_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_din.sv
// Scoreboard bench for ldpc_din: two instances (SHIFT=0 and SHIFT=2) share
// one stimulus stream; expected RAM writes are queued as samples are driven.
module tb_ldpc_din;
  import ldpc_pkg::*;

  typedef struct {
    logic [9:0]  addr;
    logic [71:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dec_busy = 1'b0;
  logic sync0, err0, drop0;
  logic sync2, err2, drop2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt0 = 0;
  int wr_cnt2 = 0;
  int base0;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  logic [71:0] m_w0, m_w2;
  int m_lane = 0;
  int m_word = 768;

  logic [71:0] ram0 [768];
  logic [71:0] ram2 [768];

  ldpc_din_if b0 ();
  ldpc_din_if b2 ();

  ldpc_din #(.SHIFT(0)) dut0 (
    .clk        (clk),
    .reset_n    (rst_n),
    .dec_busy   (dec_busy),
    .sync_out   (sync0),
    .frame_err  (err0),
    .frame_drop (drop0),
    .bus        (b0)
  );

  ldpc_din #(.SHIFT(2)) dut2 (
    .clk        (clk),
    .reset_n    (rst_n),
    .dec_busy   (dec_busy),
    .sync_out   (sync2),
    .frame_err  (err2),
    .frame_drop (drop2),
    .bus        (b2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference requantizer: floor division by 2^sh, then symmetric clamp.
  function automatic int ref_q(input int v, input int sh);
    int d;
    int r;
    d = 1 << sh;
    if (v >= 0) r = v / d;
    else        r = -((-v + d - 1) / d);
    if (r > 31)  r = 31;
    if (r < -31) r = -31;
    return r;
  endfunction

  function automatic int pat(input int k, input int mode);
    int tbl [16] = '{127, -128, -5, 5, 0, 1, -1, 64, -64, 100, -100, 3, -3, 31, -32, 12};
    if (mode == 0) return (k % 64) - 32;
    return tbl[k % 16];
  endfunction

  // Write monitor: pop the scoreboard on every wr_en.
  always @(negedge clk) begin
    if (b0.wr_en) begin
      if (q0.size() == 0) begin
        chk("wr0_unexpected", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("wr0_addr", b0.wr_addr, e0.addr);
        chk("wr0_data", b0.wr_data, e0.data);
        chk("wr0_cycle", cyc, e0.cyc);
      end
      ram0[b0.wr_addr] = b0.wr_data;
      wr_cnt0++;
    end
    if (b2.wr_en) begin
      if (q2.size() == 0) begin
        chk("wr2_unexpected", 1, 0);
      end else begin
        e2 = q2.pop_front();
        chk("wr2_addr", b2.wr_addr, e2.addr);
        chk("wr2_data", b2.wr_data, e2.data);
        chk("wr2_cycle", cyc, e2.cyc);
      end
      ram2[b2.wr_addr] = b2.wr_data;
      wr_cnt2++;
    end
  end

  // Drive one sample (called #1 after a posedge); returns #1 after it is taken.
  task automatic put(input int v, input bit sop, input int gap);
    logic [7:0] d;
    exp_t e;
    d = v[7:0];
    b0.din_valid = 1'b1; b0.din_sop = sop; b0.din = d;
    b2.din_valid = 1'b1; b2.din_sop = sop; b2.din = d;
    if (sop) begin
      m_lane = 0;
      m_word = 0;
    end
    if (m_word < 768) begin
      m_w0[m_lane*6 +: 6] = 6'(ref_q(v, 0));
      m_w2[m_lane*6 +: 6] = 6'(ref_q(v, 2));
      m_lane++;
      if (m_lane == 12) begin
        e.addr = 10'(m_word); e.cyc = cyc + 1;
        e.data = m_w0; q0.push_back(e);
        e.data = m_w2; q2.push_back(e);
        m_lane = 0;
        m_word++;
      end
    end
    @(posedge clk); #1;
    b0.din_valid = 1'b0; b0.din_sop = 1'b0;
    b2.din_valid = 1'b0; b2.din_sop = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int n, input int gap, input int mode,
                            input int restart_at, input bit full_end);
    int idx;
    bit sop;
    for (int k = 0; k < n; k++) begin
      sop = (k == 0) || (k == restart_at);
      idx = (k >= restart_at) ? k - restart_at : k;
      put(pat(idx, mode), sop, (k == n - 1) ? 0 : gap);
      if (k == 0) begin
        chk("sync_rise", sync0, 1);
        chk("no_err_at_sop", err0, 0);
      end
      if (k == restart_at) begin
        chk("frame_err0", err0, 1);
        chk("frame_err2", err2, 1);
        chk("sync_held_restart", sync0, 1);
      end
    end
    if (full_end) begin
      chk("last_wr_en", b0.wr_en, 1);
      chk("last_wr_addr", b0.wr_addr, 767);
      chk("sync_before_fall", sync0, 1);
      @(posedge clk); #1;
      chk("sync_fall0", sync0, 0);
      chk("sync_fall2", sync2, 0);
      chk("wr_en_single", b0.wr_en, 0);
      chk("ready_after_done", b0.ready, 1);
      chk("q0_drained", q0.size(), 0);
      chk("q2_drained", q2.size(), 0);
    end
  endtask

  initial begin
    int w0_exp [12] = '{-31, -31, -30, -29, -28, -27, -26, -25, -24, -23, -22, -21};
    int sat_exp [4] = '{31, -31, -2, 1};
    int tmp;

    b0.din_valid = 1'b0; b0.din_sop = 1'b0; b0.din = '0;
    b2.din_valid = 1'b0; b2.din_sop = 1'b0; b2.din = '0;
    #12;
    chk("rst_ready", b0.ready, 1);
    chk("rst_sync", sync0, 0);
    chk("rst_wr_en", b0.wr_en, 0);
    chk("rst_wr_addr", b0.wr_addr, 0);
    chk("rst_wr_data", b0.wr_data, 0);
    chk("rst_frame_err", err0, 0);
    chk("rst_frame_drop", drop0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Contiguous full frame.
    base0 = wr_cnt0;
    send_frame(9216, 0, 0, 9216, 1'b1);
    chk("full_writes", wr_cnt0 - base0, 768);
    for (int i = 0; i < 12; i++) begin
      tmp = w0_exp[i];
      chk("word0_lane", ram0[0][i*6 +: 6], tmp[5:0]);
    end

    // Valid on alternate cycles.
    base0 = wr_cnt0;
    send_frame(9216, 1, 0, 9216, 1'b1);
    chk("gappy_writes", wr_cnt0 - base0, 768);

    // Restart mid-frame at sample 5000.
    base0 = wr_cnt0;
    send_frame(5000 + 9216, 0, 0, 5000, 1'b1);
    chk("restart_writes", wr_cnt0 - base0, 416 + 768);

    // sop while the decoder is busy.
    dec_busy = 1'b1;
    #1;
    chk("ready_busy", b0.ready, 0);
    base0 = wr_cnt0;
    b0.din_valid = 1'b1; b0.din_sop = 1'b1; b0.din = 8'h11;
    b2.din_valid = 1'b1; b2.din_sop = 1'b1; b2.din = 8'h11;
    @(posedge clk); #1;
    b0.din_valid = 1'b0; b0.din_sop = 1'b0;
    b2.din_valid = 1'b0; b2.din_sop = 1'b0;
    chk("frame_drop0", drop0, 1);
    chk("frame_drop2", drop2, 1);
    chk("drop_sync", sync0, 0);
    chk("drop_ready", b0.ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("drop_pulse_end", drop0, 0);
    chk("drop_no_write", wr_cnt0 - base0, 0);
    dec_busy = 1'b0;
    #1;
    chk("ready_release", b0.ready, 1);

    // sop on the final sample of word 767, saturation pattern.
    base0 = wr_cnt0;
    send_frame(9215 + 9216, 0, 1, 9215, 1'b1);
    chk("late_sop_writes", wr_cnt0 - base0, 767 + 768);
    for (int i = 0; i < 4; i++) begin
      tmp = sat_exp[i];
      chk("sat_lane", ram2[0][i*6 +: 6], tmp[5:0]);
    end

    // Reset after 300 words, right as the last write is presented.
    base0 = wr_cnt0;
    send_frame(3600, 0, 0, 3600, 1'b0);
    chk("pre_reset_wr_en", b0.wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", b0.wr_en, 0);
    chk("rst_mid_sync", sync0, 0);
    chk("rst_mid_sync2", sync2, 0);
    chk("rst_mid_addr", b0.wr_addr, 0);
    chk("rst_mid_ready", b0.ready, 1);
    chk("rst_mid_writes", wr_cnt0 - base0, 299);
    q0.delete();
    q2.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    base0 = wr_cnt0;
    send_frame(24, 0, 0, 24, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_reset_writes", wr_cnt0 - base0, 2);
    chk("post_reset_q0", q0.size(), 0);
    chk("post_reset_q2", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_din.md
Name: ldpc_din

Overview:
- Input loader directly upstream of the LDPC decoder controller.
- Accepts a serial stream of signed soft bits framed by a start-of-frame strobe, then requantizes and saturates each sample.
- Packs 12 samples per word and writes the 768 words of one 9216-bit codeword into the LQ/channel RAM.
- Generates the sync pulse the controller consumes. The falling edge of sync_out marks "frame fully written" and starts decoding.

Parameters:
- IW, 8, input soft-bit width (two's complement)
- QW, 6, stored LLR width (two's complement)
- SHIFT, 2, arithmetic right shift applied before saturation (0..IW-QW)
- LANES, 12, LLRs packed per RAM word
- WORDS, 768, RAM words per codeword (LANES*WORDS = 9216)
- AW, 10, RAM address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- din_valid  in  1  input sample valid
- din_sop  in  1  first sample of a codeword; qualified by din_valid
- din  in  IW  signed soft bit
- dec_busy  in  1  decoder busy (controller busy output)
- ready  out  1  loader can accept a new frame
- sync_out  out  1  frame-load window; drives controller sync_in
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM word address
- wr_data  out  LANES*QW  packed LLR word
- frame_err  out  1  one-cycle pulse: frame aborted or restarted
- frame_drop  out  1  one-cycle pulse: sop received while not ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: ready=1, sync_out=0, wr_en=0, wr_addr=0, wr_data=0, frame_err=0, frame_drop=0. Internal state is IDLE with lane and word counters at 0.
- Quantize (combinational): q = din >>> SHIFT, arithmetic shift.
  - Saturate q to [-(2^(QW-1)-1), +(2^(QW-1)-1)], which is symmetric; for QW=6 the range is [-31, +31].
  - The most-negative code -32 is never produced.
- States:
  - IDLE: ready = !dec_busy.
    - din_valid & din_sop & ready: store q in lane 0, lane counter := 1, word counter := 0, go to LOAD.
    - din_valid & din_sop & !ready: frame_drop pulse next cycle; stay in IDLE.
    - din_valid without sop: ignored.
  - LOAD: ready = 0. Each din_valid without sop stores q in the current lane and increments the lane counter.
    - Lane 0 = first sample and sits at wr_data[QW-1:0]; lane k sits at bits [k*QW +: QW].
    - When lane 11 is written: on the next cycle wr_en=1 for exactly one cycle, wr_addr = word counter, wr_data = packed word. The lane counter wraps to 0 and the word counter increments.
    - Gaps in din_valid are allowed with no timeout.
    - After the write of word WORDS-1 (767), go to DONE.
  - DONE: lasts one cycle; sync_out drops; then return to IDLE.
- Latency: the final sample of a word is accepted at cycle n; wr_en occurs at cycle n+1.
- sync_out timing:
  - Rises the cycle after the sop is accepted and is held high through LOAD.
  - Falls in the cycle after the wr_en of word 767.
  - The controller sees the falling edge only once the whole frame is in RAM.
- dec_busy: only sampled in IDLE for ready. It is ignored during LOAD because it is not expected to rise there.
- Boundaries:
  - sop while in LOAD: frame_err pulse. The restart takes that sample as lane 0 of word 0 and sync_out stays high. Any partial word is discarded and not written.
  - A sop arriving in the same cycle as the lane-11 sample of word 767: treated as sop. Restart, frame_err pulses, and word 767 is not written.
  - sop arriving in the DONE cycle: accepted only if dec_busy=0, otherwise frame_drop. The controller will normally assert busy within 2 cycles; a frame offered before busy rises is accepted.
  - Reset asserted mid-frame: all outputs return to reset values immediately. No partial write is issued.
  - wr_data holds its last value when wr_en=0.

Decomposition:
- Package ldpc_pkg holds:
  - LDPC_N=9216, LANES=12, WORDS=768, QW, AW
  - the state encoding as a one-hot typedef: IDLE/LOAD/DONE
  - the saturate-limit constants
- Sub-module ldpc_din_quant: combinational shift plus symmetric saturation, IW in and QW out. It is reused by other soft-bit ingest paths.
- Packing, counters and the FSM stay in ldpc_din.

Test Plan:
- Full frame: 9216 samples with din[k] = (k mod 64) - 32, contiguous valid, SHIFT=0 -> exactly 768 wr_en pulses with addr 0..767. Word 0 lanes hold -31 (saturated), -31, -30, …, -21. sync_out falls 1 cycle after the addr-767 write.
- Saturation, SHIFT=2: din=+127 -> +31; din=-128 -> -31; din=-5 -> -2; din=+5 -> +1.
- Gappy input: valid on alternate cycles for a full frame -> identical RAM image to the contiguous case, and each wr_en is 1 cycle after the 12th sample.
- Mid-frame sop at sample 5000 -> frame_err pulse, no write of partial word 416. Addresses restart at 0 and 768 further writes follow.
- sop with dec_busy=1 in IDLE -> frame_drop pulse, no wr_en, sync_out stays 0, ready=0. Releasing dec_busy then sending a sop -> normal load.
- reset_n asserted low after 300 words -> sync_out and wr_en are 0 immediately. A new frame after release writes from addr 0.
